// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: one bit per cycle for MUL, MULH, DIV and REM.
// A start pulse in IDLE issues an operation; the result is held in DONE until stall drops.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [1:0]  OP_MUL  = 2'b00;
    localparam logic [1:0]  OP_MULH = 2'b01;
    localparam logic [1:0]  OP_DIV  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         op_q;
    logic               sign_a;
    logic               sign_b;
    logic               dz_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opd;

    logic               div_zero_c;
    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;
    logic [WIDTH:0]     mul_sum_c;
    logic [WIDTH:0]     div_shift_c;
    logic [WIDTH:0]     div_trial_c;
    logic [WIDTH-1:0]   iter_hi_c;
    logic [WIDTH-1:0]   iter_lo_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   quot_c;
    logic [WIDTH-1:0]   rem_c;
    logic [WIDTH-1:0]   result_c;
    logic               busy_c;
    logic               done_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Divide-by-zero skips the iterations (counter loaded with 0) but still takes the fix-up cycle
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (cnt == '0) state_next = S_DONE;
            S_DONE:  if (!stall) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Iteration step, sign fix-up and flag decode
    always_comb begin
        div_zero_c  = op[1] && (b == '0);
        a_mag_c     = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag_c     = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

        mul_sum_c   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opd : WIDTH'(0))};
        div_shift_c = {acc_hi, acc_lo[WIDTH-1]};
        div_trial_c = div_shift_c - {1'b0, opd};

        iter_hi_c   = mul_sum_c[WIDTH:1];
        iter_lo_c   = {mul_sum_c[0], acc_lo[WIDTH-1:1]};
        if (op_q[1]) begin
            if (!div_trial_c[WIDTH]) begin
                iter_hi_c = div_trial_c[WIDTH-1:0];
                iter_lo_c = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                iter_hi_c = div_shift_c[WIDTH-1:0];
                iter_lo_c = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end

        prod_c = {acc_hi, acc_lo};
        if (sign_a ^ sign_b) prod_c = ~prod_c + (2*WIDTH)'(1);
        quot_c = (sign_a ^ sign_b) ? (~acc_lo + WIDTH'(1)) : acc_lo;
        rem_c  = sign_a ? (~acc_hi + WIDTH'(1)) : acc_hi;

        case (op_q)
            OP_MUL:  result_c = prod_c[WIDTH-1:0];
            OP_MULH: result_c = prod_c[2*WIDTH-1:WIDTH];
            OP_DIV:  result_c = quot_c;
            default: result_c = rem_c;
        endcase
        if (dz_q) result_c = op_q[0] ? acc_lo : '1;

        busy_c = (state_next != S_IDLE);
        done_c = (state_next == S_DONE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q        <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            dz_q        <= 1'b0;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opd         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= busy_c;
            done <= done_c;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        sign_a <= signed_op & a[WIDTH-1];
                        sign_b <= signed_op & b[WIDTH-1];
                        dz_q   <= div_zero_c;
                        acc_hi <= '0;
                        acc_lo <= div_zero_c ? a : a_mag_c;
                        opd    <= b_mag_c;
                        cnt    <= div_zero_c ? CNT_W'(0) : CNT_W'(WIDTH);
                    end
                end
                S_RUN: begin
                    if (cnt != '0) begin
                        acc_hi <= iter_hi_c;
                        acc_lo <= iter_lo_c;
                        cnt    <= cnt - CNT_W'(1);
                    end else begin
                        result      <= result_c;
                        div_by_zero <= dz_q;
                    end
                end
                S_DONE: begin
                    if (!stall) div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit (WIDTH=16): results, latency, stall hold,
// ignored start pulses and asynchronous reset mid-operation.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        start;
    logic [1:0]  op;
    logic        signed_op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    ex_muldiv_unit #(.WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .start       (start),
        .op          (op),
        .signed_op   (signed_op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure latency to done, check result, optional stall hold and start noise
    task automatic run_op(input string tag, input logic [1:0] o, input logic s,
                          input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] exp_r, input logic exp_dz, input int exp_lat,
                          input logic hold, input logic noise);
        int lat;
        @(negedge clk);
        stall = hold;
        start = 1'b1; op = o; signed_op = s; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); op = 2'($urandom); signed_op = 1'($urandom);
        check({tag, "_busy"}, {30'd0, busy, done}, {30'd0, 1'b1, (exp_lat == 0)});
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (noise && (lat == 5 || lat == 10)) begin
                start = 1'b1; op = 2'b10; b = 16'h0000; a = 16'hDEAD;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, {14'd0, done, div_by_zero, result}, {14'd0, 1'b1, exp_dz, exp_r});
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                start = (i == 3);
                op = 2'b00; a = 16'h0003; b = 16'h0003;
                @(posedge clk);
                #1;
                check({tag, "_hold"}, {13'd0, busy, done, div_by_zero, result},
                      {13'd0, 1'b1, 1'b1, exp_dz, exp_r});
            end
            start = 1'b0;
            @(negedge clk);
            stall = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, "_idle"}, {29'd0, busy, done, div_by_zero}, 32'd0);
        check({tag, "_keep"}, {16'd0, result}, {16'd0, exp_r});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; start = 1'b0; op = 2'b00; signed_op = 1'b0;
        a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", {13'd0, busy, done, div_by_zero, result}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mul_u",     2'b00, 1'b0, 16'd7,    16'd6,    16'h002A, 1'b0, 17, 1'b0, 1'b0);
        run_op("mul_s",     2'b00, 1'b1, 16'hFFFD, 16'd5,    16'hFFF1, 1'b0, 17, 1'b0, 1'b0);
        run_op("mulh_s",    2'b01, 1'b1, 16'hFFFD, 16'd5,    16'hFFFF, 1'b0, 17, 1'b0, 1'b0);
        run_op("mulh_u",    2'b01, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 17, 1'b0, 1'b0);
        run_op("mul_u_max", 2'b00, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 17, 1'b0, 1'b0);
        run_op("div_u",     2'b10, 1'b0, 16'd100,  16'd7,    16'h000E, 1'b0, 17, 1'b0, 1'b0);
        run_op("rem_u",     2'b11, 1'b0, 16'd100,  16'd7,    16'h0002, 1'b0, 17, 1'b0, 1'b0);
        run_op("div_s",     2'b10, 1'b1, 16'hFFF9, 16'd2,    16'hFFFD, 1'b0, 17, 1'b0, 1'b0);
        run_op("rem_s",     2'b11, 1'b1, 16'hFFF9, 16'd2,    16'hFFFF, 1'b0, 17, 1'b0, 1'b0);
        run_op("div_s_pos", 2'b10, 1'b1, 16'd7,    16'hFFFE, 16'hFFFD, 1'b0, 17, 1'b0, 1'b0);
        run_op("rem_s_pos", 2'b11, 1'b1, 16'd7,    16'hFFFE, 16'h0001, 1'b0, 17, 1'b0, 1'b0);
        run_op("div_ovf",   2'b10, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 17, 1'b0, 1'b0);
        run_op("rem_ovf",   2'b11, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 1'b0, 17, 1'b0, 1'b0);
        run_op("div_z",     2'b10, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1,  1'b0, 1'b0);
        run_op("rem_z",     2'b11, 1'b0, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1,  1'b0, 1'b0);
        run_op("rem_z_s",   2'b11, 1'b1, 16'hFFF9, 16'h0000, 16'hFFF9, 1'b1, 1,  1'b0, 1'b0);
        run_op("div_noise", 2'b10, 1'b0, 16'hFFFF, 16'h0010, 16'h0FFF, 1'b0, 17, 1'b0, 1'b1);
        run_op("mul_hold",  2'b00, 1'b0, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 17, 1'b1, 1'b1);
        run_op("divz_hold", 2'b10, 1'b1, 16'h0042, 16'h0000, 16'hFFFF, 1'b1, 1,  1'b1, 1'b0);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = 2'b00; signed_op = 1'b0; a = 16'd100; b = 16'd200;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid", {13'd0, busy, done, div_by_zero, result}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_done", {30'd0, busy, done}, 32'd0);
        run_op("mul_after_rst", 2'b00, 1'b0, 16'd3, 16'd4, 16'h000C, 1'b0, 17, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
